// File: rtl/modulation_demodulator.sv
// ASK/BPSK demodulator: integrates one symbol of centered samples, then decides a bit and packs bytes MSB-first.
// Latency: bit_valid one cycle after the edge accepting the final sample; sample_valid=0 stalls integration.
module modulation_demodulator #(
    parameter int SAMPLES_PER_BIT = 64,
    parameter int ASK_THRESH      = 32768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mode,
    input  logic        sample_valid,
    input  logic [11:0] mod_sample,
    input  logic [11:0] ref_sample,
    output logic        bit_out,
    output logic        bit_valid,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        busy
);

    localparam int CW = $clog2(SAMPLES_PER_BIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLES_PER_BIT - 1);
    localparam logic signed [32:0] ASK_T = 33'(ASK_THRESH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INTEGRATE = 2'd1,
        DECIDE    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic signed [32:0] acc, acc_nxt, acc_sum;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              mode_q, mode_nxt;
    logic              bit_nxt, bit_valid_nxt, decided;
    logic [7:0]        shreg, shreg_nxt, byte_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic              byte_valid_nxt;
    logic signed [32:0] term_latched, term_new;

    // Per-sample contribution: |m| for ASK, m*r for BPSK, both sign-extended to the accumulator width.
    function automatic logic signed [32:0] sample_term(input logic md, input logic [11:0] ms,
                                                       input logic [11:0] rs);
        logic signed [12:0] m, r;
        logic signed [24:0] m_ext, r_ext, prod;
        logic [12:0]        mag;
        m     = $signed({1'b0, ms}) - 13'sd2048;
        r     = $signed({1'b0, rs}) - 13'sd2048;
        m_ext = {{12{m[12]}}, m};
        r_ext = {{12{r[12]}}, r};
        prod  = m_ext * r_ext;
        mag   = m[12] ? 13'(-m) : 13'(m);
        if (md)
            return {{8{prod[24]}}, prod};
        else
            return $signed({20'd0, mag});
    endfunction

    assign term_latched = sample_term(mode_q, mod_sample, ref_sample);
    assign term_new     = sample_term(mode, mod_sample, ref_sample);
    assign acc_sum      = acc + term_latched;
    assign decided      = mode_q ? ~acc_sum[32] : (acc_sum >= ASK_T);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        cnt_nxt        = cnt;
        mode_nxt       = mode_q;
        bit_nxt        = bit_out;
        bit_valid_nxt  = 1'b0;
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        byte_nxt       = byte_out;
        byte_valid_nxt = 1'b0;
        if (!enable) begin
            state_nxt   = IDLE;
            acc_nxt     = '0;
            cnt_nxt     = '0;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        state_nxt = INTEGRATE;
                        mode_nxt  = mode;
                        acc_nxt   = term_new;
                        cnt_nxt   = CW'(1);
                    end
                end
                INTEGRATE: begin
                    if (sample_valid) begin
                        if (cnt == LAST_CNT) begin
                            // Decision registered here so bit_out is already valid during DECIDE.
                            state_nxt     = DECIDE;
                            acc_nxt       = '0;
                            cnt_nxt       = '0;
                            bit_nxt       = decided;
                            bit_valid_nxt = 1'b1;
                            shreg_nxt     = {shreg[6:0], decided};
                            bit_cnt_nxt   = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_nxt       = {shreg[6:0], decided};
                                byte_valid_nxt = 1'b1;
                            end
                        end else begin
                            acc_nxt = acc_sum;
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                DECIDE: begin
                    state_nxt = INTEGRATE;
                    if (sample_valid) begin
                        mode_nxt = mode;
                        acc_nxt  = term_new;
                        cnt_nxt  = CW'(1);
                    end else begin
                        mode_nxt = mode;
                        acc_nxt  = '0;
                        cnt_nxt  = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            mode_q     <= 1'b0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            mode_q     <= mode_nxt;
            bit_out    <= bit_nxt;
            bit_valid  <= bit_valid_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_out   <= byte_nxt;
            byte_valid <= byte_valid_nxt;
        end
    end

endmodule

// File: tb/tb_modulation_demodulator.sv
// Directed bench for modulation_demodulator: ASK/BPSK decisions, stalls, mode latching, byte packing, aborts.
module tb_modulation_demodulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mode;
    logic        sample_valid;
    logic [11:0] mod_sample;
    logic [11:0] ref_sample;
    logic        bit_out;
    logic        bit_valid;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int bits_seen = 0;
    int bytes_seen = 0;
    int exp_bits = 0;
    int exp_bytes = 0;

    modulation_demodulator dut (
        .clk          (clk),
        .reset        (rst),
        .enable       (enable),
        .mode         (mode),
        .sample_valid (sample_valid),
        .mod_sample   (mod_sample),
        .ref_sample   (ref_sample),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bit_valid)  bits_seen++;
        if (byte_valid) bytes_seen++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [11:0] m, input logic [11:0] r);
        sample_valid = v;
        mod_sample   = m;
        ref_sample   = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] sine(input int i);
        return 12'($rtoi(2048.0 + 1500.0 * $sin(6.283185307 * i / 64.0)));
    endfunction

    // kind: 0 ASK +-1000 alternating, 1 constant midscale, 2 BPSK in-phase, 3 BPSK inverted.
    task automatic sym(input int kind, input int n, input bit gap, input bit exp_bit, input int flip_at);
        logic [11:0] m, r;
        for (int i = 0; i < n; i++) begin
            if (gap) step(1'b0, 12'd0, 12'd0);
            if (i == flip_at) mode = 1'b1;
            case (kind)
                0:       begin m = (i % 2 == 0) ? 12'd3048 : 12'd1048; r = 12'd2048; end
                1:       begin m = 12'd2048; r = 12'd2048; end
                2:       begin r = sine(i); m = r; end
                default: begin r = sine(i); m = 12'd4096 - r; end
            endcase
            if (n == 64 && i == 63) chk("no_early_bit_valid", int'(bit_valid), 0);
            step(1'b1, m, r);
        end
        if (n == 64) begin
            exp_bits++;
            chk("bit_valid_latency", int'(bit_valid), 1);
            chk("bit_out", int'(bit_out), int'(exp_bit));
        end
    endtask

    task automatic pause_enable();
        enable = 1'b0;
        step(1'b0, 12'd2048, 12'd2048);
        chk("busy_after_disable", int'(busy), 0);
        enable = 1'b1;
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1; enable = 1'b0; mode = 1'b0;
        sample_valid = 1'b0; mod_sample = 12'd2048; ref_sample = 12'd2048;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bit_out", int'(bit_out), 0);
        chk("rst_bit_valid", int'(bit_valid), 0);
        chk("rst_byte_out", int'(byte_out), 8'h00);
        chk("rst_byte_valid", int'(byte_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step(1'b0, 12'd2048, 12'd2048);
        enable = 1'b1;
        step(1'b0, 12'd2048, 12'd2048);
        chk("idle_busy_no_sample", int'(busy), 0);

        // ASK: alternating +-1000 gives 64000 >= 32768, midscale gives 0.
        sym(0, 64, 1'b0, 1'b1, -1);
        chk("busy_in_decide", int'(busy), 1);
        sym(1, 64, 1'b0, 1'b0, -1);
        sym(0, 64, 1'b1, 1'b1, -1);
        step(1'b0, 12'd2048, 12'd2048);
        chk("bits_after_ask", bits_seen, exp_bits);
        chk("no_byte_yet", bytes_seen, 0);

        // BPSK, 8 back-to-back symbols alternating phase -> 8'hAA.
        pause_enable();
        mode = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sym((s % 2 == 0) ? 2 : 3, 64, 1'b0, (s % 2 == 0), -1);
            if (s < 7) chk("byte_valid_early", int'(byte_valid), 0);
        end
        exp_bytes++;
        chk("bpsk_byte_valid", int'(byte_valid), 1);
        chk("bpsk_byte_out", int'(byte_out), 8'hAA);
        step(1'b0, 12'd2048, 12'd2048);
        chk("bpsk_byte_count", bytes_seen, exp_bytes);
        chk("bpsk_bit_count", bits_seen, exp_bits);

        // Mode flip mid-period: midscale decides 0 as ASK and 1 as BPSK (zero correlation).
        pause_enable();
        mode = 1'b0;
        sym(1, 64, 1'b0, 1'b0, 30);
        sym(1, 64, 1'b0, 1'b1, -1);

        // Reset at sample 40 of bit 5 discards the partial byte.
        pause_enable();
        mode = 1'b0;
        for (int s = 0; s < 5; s++) sym(0, 64, 1'b0, 1'b1, -1);
        sym(0, 40, 1'b0, 1'b0, -1);
        rst = 1'b1;
        step(1'b0, 12'd2048, 12'd2048);
        chk("abort_rst_busy", int'(busy), 0);
        rst = 1'b0;
        step(1'b0, 12'd2048, 12'd2048);
        chk("abort_rst_bits", bits_seen, exp_bits);
        chk("abort_rst_byte_out", int'(byte_out), 8'h00);
        pat = 8'hCB;
        for (int s = 0; s < 8; s++) begin
            sym(pat[7-s] ? 0 : 1, 64, 1'b0, pat[7-s], -1);
            if (s == 6) chk("rst_partial_no_byte", bytes_seen, exp_bytes);
        end
        exp_bytes++;
        chk("rst_fresh_byte", int'(byte_out), 8'hCB);
        step(1'b0, 12'd2048, 12'd2048);
        chk("rst_fresh_byte_count", bytes_seen, exp_bytes);

        // enable=0 at sample 40 of bit 5 also discards; outputs hold.
        for (int s = 0; s < 5; s++) sym(1, 64, 1'b0, 1'b0, -1);
        sym(0, 40, 1'b0, 1'b0, -1);
        pause_enable();
        chk("abort_en_bits", bits_seen, exp_bits);
        chk("abort_en_byte_hold", int'(byte_out), 8'hCB);
        chk("abort_en_bit_hold", int'(bit_out), 0);
        pat = 8'h71;
        for (int s = 0; s < 8; s++) begin
            sym(pat[7-s] ? 0 : 1, 64, 1'b0, pat[7-s], -1);
            if (s == 6) chk("en_partial_no_byte", bytes_seen, exp_bytes);
        end
        exp_bytes++;
        chk("en_fresh_byte", int'(byte_out), 8'h71);
        step(1'b0, 12'd2048, 12'd2048);
        chk("en_fresh_byte_count", bytes_seen, exp_bytes);
        chk("final_bit_count", bits_seen, exp_bits);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modulation_demodulator.md
MODULATION_DEMODULATOR -- requirements
Module: modulation_demodulator

Interface
REQ-001 Parameter SAMPLES_PER_BIT, default 64: input samples per symbol, legal range 2..256.
REQ-002 Parameter ASK_THRESH, default 32768: unsigned energy threshold for an ASK "1" decision.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  demodulator run enable.
REQ-006 mode  input  1  0 = ASK, 1 = BPSK.
REQ-007 sample_valid  input  1  qualifies mod_sample/ref_sample this cycle.
REQ-008 mod_sample  input  12  received modulated sample, offset binary (midscale 2048).
REQ-009 ref_sample  input  12  local carrier reference, offset binary, phase-aligned to mod_sample.
REQ-010 bit_out  output  1  last decided bit.
REQ-011 bit_valid  output  1  one-cycle pulse when bit_out is updated.
REQ-012 byte_out  output  8  last 8 decided bits, first-received bit in MSB.
REQ-013 byte_valid  output  1  one-cycle pulse when byte_out is updated.
REQ-014 busy  output  1  high while a symbol period is being integrated.

Function
REQ-015 FSM states: IDLE, INTEGRATE, DECIDE.
REQ-016 IDLE -> INTEGRATE on first cycle with enable=1 and sample_valid=1; that sample is the first sample of the period.
REQ-017 mode is latched on IDLE->INTEGRATE and DECIDE->INTEGRATE transitions; changes mid-period take effect only at the next period.
REQ-018 Centering: m = mod_sample - 2048, r = ref_sample - 2048, both signed 13-bit.
REQ-019 ASK accumulation: acc += |m| (unsigned, 21-bit minimum, no overflow at SAMPLES_PER_BIT=256).
REQ-020 BPSK accumulation: acc += m*r (signed 25-bit product, signed 33-bit accumulator, no overflow).
REQ-021 Sample counter increments only on sample_valid=1; sample_valid=0 stalls integration with acc and counter held.
REQ-022 After SAMPLES_PER_BIT valid samples the FSM enters DECIDE for exactly one cycle.
REQ-023 DECIDE: ASK bit = (acc >= ASK_THRESH); BPSK bit = (acc >= 0); bit_out updated, bit_valid pulsed, acc and sample counter cleared.
REQ-024 Latency: bit_valid asserts on the cycle after the clock edge that accepts the final sample of the period.
REQ-025 A sample_valid in the DECIDE cycle is accepted as sample 1 of the next period (no lost samples); FSM returns to INTEGRATE.
REQ-026 If no sample_valid in DECIDE cycle, FSM goes to INTEGRATE with counter 0 when enable=1, else IDLE.
REQ-027 Each decided bit shifts into an 8-bit register (shift left, new bit at LSB); bit counter 0..7 wraps.
REQ-028 On the 8th bit byte_out loads the full register and byte_valid pulses in the same cycle as that bit_valid.
REQ-029 enable=0 in any state: next cycle FSM -> IDLE, acc, sample and bit counters cleared; partial period and partial byte discarded; bit_out/byte_out hold.
REQ-030 busy = 1 in INTEGRATE and DECIDE, 0 in IDLE.

Reset
REQ-031 On reset: FSM IDLE, acc/counters 0, bit_out 0, bit_valid 0, byte_out 8'h00, byte_valid 0, busy 0.
REQ-032 Reset asserted mid-period aborts it immediately; no bit_valid or byte_valid is produced for the aborted period.

Verification
REQ-033 ASK, SPB=64, mod alternating 2048+1000/2048-1000 for 64 samples -> acc=64000, bit_valid with bit_out=1.
REQ-034 ASK, mod constant 2048 for 64 samples -> acc=0, bit_out=0.
REQ-035 BPSK, ref = 12-bit sine, mod = ref then 4096-ref on alternate symbols for 8 symbols -> byte_out=8'hAA, one byte_valid pulse.
REQ-036 sample_valid toggled every other cycle for one period -> bit_valid exactly after 64 valid samples, decision identical to continuous case.
REQ-037 mode flipped ASK->BPSK at sample 30 of a period -> that period decided as ASK, next as BPSK.
REQ-038 reset (and separately enable=0) at sample 40 of bit 5 -> no pulses; next byte_valid only after 8 fresh full bits.
